pipe_ctrl: RTL and testbench

- Pipelined control unit for the 5-stage RV32I core; successor to the single-cycle combinational opcode decoder.
- Decodes the ID-stage instruction into a control bundle and carries it through ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards (stall plus bubble) and taken-branch flushes, and generates forwarding selects for the EX-stage ALU operands.
- Sits between the fetch/IF-ID register and the datapath; owns no data values, only control and register addresses.

---
 rtl/pipe_ctrl_pkg.sv | 49 ++++
 rtl/pipe_ctrl_decode.sv | 83 ++++++++
 rtl/pipe_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared opcodes, encodings and the control bundle carried down the pipeline.
package pipe_ctrl_pkg;

  // RV32I major opcodes (instr[6:0])
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // ALU operation class handed to the EX stage
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_BR  = 2'b01;
  localparam logic [1:0] ALU_R   = 2'b10;
  localparam logic [1:0] ALU_I   = 2'b11;

  // Forwarding mux selects for the EX-stage operands
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       jump;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // The younger producer (EX/MEM) always wins over MEM/WB.
  function automatic logic [1:0] fwd_sel(input logic hit_mem, input logic hit_wb);
    if (hit_mem) begin
      return FWD_MEM;
    end else if (hit_wb) begin
      return FWD_WB;
    end
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_ctrl_decode.sv
// Combinational opcode decoder: ID-stage control bundle and operand usage.
module ctrl_decode
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned RADDR_W = 5
) (
  input  logic [6:0]         opcode,
  input  logic [RADDR_W-1:0] rd,
  output ctrl_t              ctrl,
  output logic               uses_rs1,
  output logic               uses_rs2,
  output logic               illegal
);

  ctrl_t raw;

  // Opcode to raw control bits; unknown opcodes decode to an all-zero bundle.
  always_comb begin
    raw      = CTRL_NOP;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    illegal  = 1'b0;
    case (opcode)
      OP_R: begin
        raw.reg_write = 1'b1;
        raw.alu_op    = ALU_R;
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
      end
      OP_IMM: begin
        raw.reg_write = 1'b1;
        raw.alu_src   = 1'b1;
        raw.alu_op    = ALU_I;
        uses_rs1      = 1'b1;
      end
      OP_LOAD: begin
        raw.reg_write  = 1'b1;
        raw.alu_src    = 1'b1;
        raw.alu_op     = ALU_ADD;
        raw.mem_read   = 1'b1;
        raw.mem_to_reg = 1'b1;
        uses_rs1       = 1'b1;
      end
      OP_STORE: begin
        raw.alu_src   = 1'b1;
        raw.alu_op    = ALU_ADD;
        raw.mem_write = 1'b1;
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
      end
      OP_BRANCH: begin
        raw.branch = 1'b1;
        raw.alu_op = ALU_BR;
        uses_rs1   = 1'b1;
        uses_rs2   = 1'b1;
      end
      OP_JAL: begin
        raw.reg_write = 1'b1;
        raw.jump      = 1'b1;
      end
      OP_JALR: begin
        raw.reg_write = 1'b1;
        raw.alu_src   = 1'b1;
        raw.jump      = 1'b1;
        uses_rs1      = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        raw.reg_write = 1'b1;
        raw.alu_src   = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  // x0 is hardwired to zero, so writes to it are dropped at decode.
  always_comb begin
    ctrl = raw;
    if (rd == '0) begin
      ctrl.reg_write = 1'b0;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipelined control unit: decode, ID/EX, EX/MEM, MEM/WB control registers,
// load-use stall, taken-branch flush and EX operand forwarding selects.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned INSTR_W   = 32,
  parameter int unsigned RADDR_W   = 5,
  parameter bit          HAZARD_EN = 1'b1,
  parameter bit          FWD_EN    = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic               instr_valid_i,
  input  logic               branch_taken_i,
  output logic               stall_o,
  output logic               flush_o,
  output logic               illegal_o,
  output logic               ex_valid_o,
  output logic               ex_alu_src_o,
  output logic               ex_branch_o,
  output logic               ex_jump_o,
  output logic [1:0]         ex_alu_op_o,
  output logic [RADDR_W-1:0] ex_rs1_o,
  output logic [RADDR_W-1:0] ex_rs2_o,
  output logic [RADDR_W-1:0] ex_rd_o,
  output logic               mem_valid_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic               wb_valid_o,
  output logic               wb_reg_write_o,
  output logic               wb_mem_to_reg_o,
  output logic [RADDR_W-1:0] wb_rd_o,
  output logic [1:0]         fwd_a_o,
  output logic [1:0]         fwd_b_o
);

  // ID-stage fields
  logic [6:0]         id_opcode;
  logic [RADDR_W-1:0] id_rd, id_rs1, id_rs2;
  ctrl_t              id_ctrl;
  logic               id_uses_rs1, id_uses_rs2, id_illegal;
  logic               id_accept, load_use;
  logic               unused_instr;

  assign id_opcode    = instr_i[6:0];
  assign id_rd        = instr_i[7 +: RADDR_W];
  assign id_rs1       = instr_i[15 +: RADDR_W];
  assign id_rs2       = instr_i[20 +: RADDR_W];
  // funct3/funct7 only matter to the ALU decoder downstream
  assign unused_instr = ^{instr_i[INSTR_W-1:25], instr_i[14:12]};

  // ID/EX
  logic               ex_valid_q, ex_valid_d;
  ctrl_t              ex_ctrl_q, ex_ctrl_d;
  logic [RADDR_W-1:0] ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d, ex_rd_q, ex_rd_d;

  // EX/MEM
  logic               mem_valid_q, mem_reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q;
  logic [RADDR_W-1:0] mem_rd_q;

  // MEM/WB
  logic               wb_valid_q, wb_reg_write_q, wb_mem_to_reg_q;
  logic [RADDR_W-1:0] wb_rd_q;

  ctrl_decode #(
    .RADDR_W (RADDR_W)
  ) u_decode (
    .opcode   (id_opcode),
    .rd       (id_rd),
    .ctrl     (id_ctrl),
    .uses_rs1 (id_uses_rs1),
    .uses_rs2 (id_uses_rs2),
    .illegal  (id_illegal)
  );

  // Hazard detection and ID-stage status; everything is held quiet during reset.
  always_comb begin
    load_use = HAZARD_EN && instr_valid_i && ex_valid_q && ex_ctrl_q.mem_read &&
               (ex_rd_q != '0) &&
               ((id_uses_rs1 && (id_rs1 == ex_rd_q)) ||
                (id_uses_rs2 && (id_rs2 == ex_rd_q)));
    flush_o   = !rst && branch_taken_i && ex_valid_q;
    // Flush beats stall: the dependent instruction is being squashed anyway.
    stall_o   = !rst && load_use && !flush_o;
    illegal_o = !rst && instr_valid_i && id_illegal;
    id_accept = instr_valid_i && !id_illegal && !stall_o && !flush_o;
  end

  // ID/EX next state: either the decoded instruction or an all-zero bubble.
  always_comb begin
    ex_valid_d = 1'b0;
    ex_ctrl_d  = CTRL_NOP;
    ex_rs1_d   = '0;
    ex_rs2_d   = '0;
    ex_rd_d    = '0;
    if (id_accept) begin
      ex_valid_d = 1'b1;
      ex_ctrl_d  = id_ctrl;
      ex_rs1_d   = id_rs1;
      ex_rs2_d   = id_rs2;
      ex_rd_d    = id_rd;
    end
  end

  // ID/EX register
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_ctrl_q  <= CTRL_NOP;
      ex_rs1_q   <= '0;
      ex_rs2_q   <= '0;
      ex_rd_q    <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_ctrl_q  <= ex_ctrl_d;
      ex_rs1_q   <= ex_rs1_d;
      ex_rs2_q   <= ex_rs2_d;
      ex_rd_q    <= ex_rd_d;
    end
  end

  // EX/MEM register: advances every cycle, bubbles already carry zero control.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid_q     <= 1'b0;
      mem_reg_write_q <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_to_reg_q    <= 1'b0;
      mem_rd_q        <= '0;
    end else begin
      mem_valid_q     <= ex_valid_q;
      mem_reg_write_q <= ex_ctrl_q.reg_write;
      mem_read_q      <= ex_ctrl_q.mem_read;
      mem_write_q     <= ex_ctrl_q.mem_write;
      mem_to_reg_q    <= ex_ctrl_q.mem_to_reg;
      mem_rd_q        <= ex_rd_q;
    end
  end

  // MEM/WB register
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q      <= 1'b0;
      wb_reg_write_q  <= 1'b0;
      wb_mem_to_reg_q <= 1'b0;
      wb_rd_q         <= '0;
    end else begin
      wb_valid_q      <= mem_valid_q;
      wb_reg_write_q  <= mem_reg_write_q;
      wb_mem_to_reg_q <= mem_to_reg_q;
      wb_rd_q         <= mem_rd_q;
    end
  end

  // Forwarding selects for the instruction currently in EX.
  always_comb begin
    logic mem_fwd_ok, wb_fwd_ok;
    mem_fwd_ok = mem_valid_q && mem_reg_write_q && (mem_rd_q != '0);
    wb_fwd_ok  = wb_valid_q && wb_reg_write_q && (wb_rd_q != '0);
    fwd_a_o    = FWD_RF;
    fwd_b_o    = FWD_RF;
    if (FWD_EN) begin
      fwd_a_o = fwd_sel(mem_fwd_ok && (mem_rd_q == ex_rs1_q),
                        wb_fwd_ok && (wb_rd_q == ex_rs1_q));
      fwd_b_o = fwd_sel(mem_fwd_ok && (mem_rd_q == ex_rs2_q),
                        wb_fwd_ok && (wb_rd_q == ex_rs2_q));
    end
  end

  assign ex_valid_o      = ex_valid_q;
  assign ex_alu_src_o    = ex_ctrl_q.alu_src;
  assign ex_branch_o     = ex_ctrl_q.branch;
  assign ex_jump_o       = ex_ctrl_q.jump;
  assign ex_alu_op_o     = ex_ctrl_q.alu_op;
  assign ex_rs1_o        = ex_rs1_q;
  assign ex_rs2_o        = ex_rs2_q;
  assign ex_rd_o         = ex_rd_q;
  assign mem_valid_o     = mem_valid_q;
  assign mem_read_o      = mem_read_q;
  assign mem_write_o     = mem_write_q;
  assign wb_valid_o      = wb_valid_q;
  assign wb_reg_write_o  = wb_reg_write_q;
  assign wb_mem_to_reg_o = wb_mem_to_reg_q;
  assign wb_rd_o         = wb_rd_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed per-cycle vectors, expected stage
// contents queued at issue and compared whenever a stage reports valid.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        branch_taken = 1'b0;
  logic        stall, flush, illegal;
  logic        ex_valid, ex_alu_src, ex_branch, ex_jump;
  logic [1:0]  ex_alu_op;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic        mem_valid, mem_read, mem_write;
  logic        wb_valid, wb_reg_write, wb_mem_to_reg;
  logic [4:0]  wb_rd;
  logic [1:0]  fwd_a, fwd_b;

  pipe_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .instr_i         (instr),
    .instr_valid_i   (instr_valid),
    .branch_taken_i  (branch_taken),
    .stall_o         (stall),
    .flush_o         (flush),
    .illegal_o       (illegal),
    .ex_valid_o      (ex_valid),
    .ex_alu_src_o    (ex_alu_src),
    .ex_branch_o     (ex_branch),
    .ex_jump_o       (ex_jump),
    .ex_alu_op_o     (ex_alu_op),
    .ex_rs1_o        (ex_rs1),
    .ex_rs2_o        (ex_rs2),
    .ex_rd_o         (ex_rd),
    .mem_valid_o     (mem_valid),
    .mem_read_o      (mem_read),
    .mem_write_o     (mem_write),
    .wb_valid_o      (wb_valid),
    .wb_reg_write_o  (wb_reg_write),
    .wb_mem_to_reg_o (wb_mem_to_reg),
    .wb_rd_o         (wb_rd),
    .fwd_a_o         (fwd_a),
    .fwd_b_o         (fwd_b)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rd, rs1, rs2;
    logic       rw, src;
    logic [1:0] op;
    logic       mr, mw, m2r, br, jmp;
  } rec_t;

  typedef struct {
    int         idx;
    bit         rst, chk, zero;
    bit         stall, flush, ill, exv, wbv;
    logic [1:0] fa, fb;
  } cyc_t;

  cyc_t cycq[$];
  rec_t exq[$], memq[$], wbq[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc_n = 0;

  localparam rec_t NOREC = '0;

  function automatic rec_t mk(input logic [4:0] rd, rs1, rs2, input logic rw, src,
                              input logic [1:0] op, input logic mr, mw, m2r, br, jmp);
    rec_t r;
    r = '{rd: rd, rs1: rs1, rs2: rs2, rw: rw, src: src, op: op,
          mr: mr, mw: mw, m2r: m2r, br: br, jmp: jmp};
    return r;
  endfunction

  function automatic logic [31:0] r_ins(input logic [4:0] rd, rs1, rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] i_ins(input logic [4:0] rd, rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] ld_ins(input logic [4:0] rd, rs1);
    return {12'd0, rs1, 3'b010, rd, 7'b0000011};
  endfunction
  function automatic logic [31:0] sw_ins(input logic [4:0] rs2, rs1, imm);
    return {7'd0, rs2, rs1, 3'b010, imm, 7'b0100011};
  endfunction
  function automatic logic [31:0] beq_ins(input logic [4:0] rs1, rs2);
    return {7'd0, rs2, rs1, 3'b000, 5'd0, 7'b1100011};
  endfunction
  function automatic logic [31:0] jal_ins(input logic [4:0] rd);
    return {20'd0, rd, 7'b1101111};
  endfunction
  function automatic logic [31:0] lui_ins(input logic [4:0] rd);
    return {20'd0, rd, 7'b0110111};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of stimulus and queue its expectations.
  task automatic step(input bit r, vld, bt, input logic [31:0] ins, input bit ck, zr,
                      input bit st, fl, il, input logic [1:0] fa, fb,
                      input bit exv, wbv, acc, input rec_t rc);
    cyc_t c;
    @(posedge clk);
    #1;
    rst          = r;
    instr_valid  = vld;
    branch_taken = bt;
    instr        = ins;
    c = '{idx: cyc_n, rst: r, chk: ck, zero: zr, stall: st, flush: fl, ill: il,
          exv: exv, wbv: wbv, fa: fa, fb: fb};
    cycq.push_back(c);
    if (acc) begin
      exq.push_back(rc);
      memq.push_back(rc);
      wbq.push_back(rc);
    end
    cyc_n++;
  endtask

  // Monitor: compare per-cycle status, pop stage records when a stage is valid.
  cyc_t cv;
  rec_t er;
  always @(negedge clk) begin
    if (cycq.size() > 0) begin
      cv = cycq.pop_front();
      if (cv.chk) begin
        if (cv.zero) begin
          chk($sformatf("c%0d_all_zero", cv.idx),
              {25'd0, stall, flush, illegal, ex_valid, ex_alu_src, ex_branch, ex_jump,
               ex_alu_op, ex_rs1, ex_rs2, ex_rd, mem_valid, mem_read, mem_write,
               wb_valid, wb_reg_write, wb_mem_to_reg, wb_rd, fwd_a, fwd_b}, 64'd0);
        end
        chk($sformatf("c%0d_stall", cv.idx), {63'd0, stall}, {63'd0, cv.stall});
        chk($sformatf("c%0d_flush", cv.idx), {63'd0, flush}, {63'd0, cv.flush});
        chk($sformatf("c%0d_illegal", cv.idx), {63'd0, illegal}, {63'd0, cv.ill});
        chk($sformatf("c%0d_fwd_a", cv.idx), {62'd0, fwd_a}, {62'd0, cv.fa});
        chk($sformatf("c%0d_fwd_b", cv.idx), {62'd0, fwd_b}, {62'd0, cv.fb});
        chk($sformatf("c%0d_ex_valid", cv.idx), {63'd0, ex_valid}, {63'd0, cv.exv});
        chk($sformatf("c%0d_wb_valid", cv.idx), {63'd0, wb_valid}, {63'd0, cv.wbv});
        if (ex_valid === 1'b1) begin
          if (exq.size() == 0) begin
            chk($sformatf("c%0d_ex_unexpected", cv.idx), 64'd1, 64'd0);
          end else begin
            er = exq.pop_front();
            chk($sformatf("c%0d_ex_bundle", cv.idx),
                {44'd0, ex_alu_src, ex_alu_op, ex_branch, ex_jump, ex_rs1, ex_rs2, ex_rd},
                {44'd0, er.src, er.op, er.br, er.jmp, er.rs1, er.rs2, er.rd});
          end
        end
        if (mem_valid === 1'b1) begin
          if (memq.size() == 0) begin
            chk($sformatf("c%0d_mem_unexpected", cv.idx), 64'd1, 64'd0);
          end else begin
            er = memq.pop_front();
            chk($sformatf("c%0d_mem_bundle", cv.idx), {62'd0, mem_read, mem_write},
                {62'd0, er.mr, er.mw});
          end
        end
        if (wb_valid === 1'b1) begin
          if (wbq.size() == 0) begin
            chk($sformatf("c%0d_wb_unexpected", cv.idx), 64'd1, 64'd0);
          end else begin
            er = wbq.pop_front();
            chk($sformatf("c%0d_wb_bundle", cv.idx), {57'd0, wb_reg_write, wb_mem_to_reg, wb_rd},
                {57'd0, er.rw, er.m2r, er.rd});
          end
        end
      end
      // Reset wipes whatever was still in flight behind the WB stage.
      if (cv.rst) begin
        exq.delete();
        memq.delete();
        wbq.delete();
      end
    end
  end

  initial begin
    //    rst vld bt instr                        ck zr st fl il fa     fb     exv wbv acc rec
    step(1, 0, 0, 32'h0,                    0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, NOREC);
    step(1, 0, 0, 32'h0,                    1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, NOREC);
    // add x1,x2,x3 ; sub x4,x1,x5 ; or x8,x1,x9
    step(0, 1, 0, r_ins(1, 2, 3),           1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1,
         mk(1, 2, 3, 1, 0, 2'b10, 0, 0, 0, 0, 0));
    step(0, 1, 0, r_ins(4, 1, 5) | 32'h4000_0000, 1, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 1,
         mk(4, 1, 5, 1, 0, 2'b10, 0, 0, 0, 0, 0));
    step(0, 1, 0, r_ins(8, 1, 9) | 32'h0000_6000, 1, 0, 0, 0, 0, 2'b10, 2'b00, 1, 0, 1,
         mk(8, 1, 9, 1, 0, 2'b10, 0, 0, 0, 0, 0));
    // lw x6,0(x2) ; add x7,x6,x1 (one stall, then WB forward)
    step(0, 1, 0, ld_ins(6, 2),             1, 0, 0, 0, 0, 2'b01, 2'b00, 1, 1, 1,
         mk(6, 2, 0, 1, 1, 2'b00, 1, 0, 1, 0, 0));
    step(0, 1, 0, r_ins(7, 6, 1),           1, 0, 1, 0, 0, 2'b00, 2'b00, 1, 1, 0, NOREC);
    step(0, 1, 0, r_ins(7, 6, 1),           1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 1,
         mk(7, 6, 1, 1, 0, 2'b10, 0, 0, 0, 0, 0));
    step(0, 0, 0, 32'h0,                    1, 0, 0, 0, 0, 2'b01, 2'b00, 1, 1, 0, NOREC);
    // lw x0,0(x2) ; add x7,x0,x1 (no stall, no write)
    step(0, 1, 0, ld_ins(0, 2),             1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1,
         mk(0, 2, 0, 0, 1, 2'b00, 1, 0, 1, 0, 0));
    step(0, 1, 0, r_ins(7, 0, 1),           1, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1, 1,
         mk(7, 0, 1, 1, 0, 2'b10, 0, 0, 0, 0, 0));
    step(0, 0, 0, 32'h0,                    1, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0, NOREC);
    // load-use pair with a taken branch: flush beats stall
    step(0, 1, 0, ld_ins(6, 2),             1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 1,
         mk(6, 2, 0, 1, 1, 2'b00, 1, 0, 1, 0, 0));
    step(0, 1, 1, r_ins(7, 6, 1),           1, 0, 0, 1, 0, 2'b00, 2'b00, 1, 1, 0, NOREC);
    step(0, 0, 0, 32'h0,                    1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, NOREC);
    // beq x1,x2 taken while in EX
    step(0, 1, 0, beq_ins(1, 2),            1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 1,
         mk(0, 1, 2, 0, 0, 2'b01, 0, 0, 0, 1, 0));
    step(0, 1, 1, r_ins(10, 11, 12),        1, 0, 0, 1, 0, 2'b00, 2'b00, 1, 0, 0, NOREC);
    step(0, 0, 0, 32'h0,                    1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, NOREC);
    // illegal opcode, then the same word without valid
    step(0, 1, 0, 32'h0000_007F,            1, 0, 0, 0, 1, 2'b00, 2'b00, 0, 1, 0, NOREC);
    step(0, 0, 0, 32'h0000_007F,            1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, NOREC);
    // fill EX/MEM/WB: addi x11,x12,5 ; sw x11,4(x12) ; jal x1
    step(0, 1, 0, i_ins(11, 12, 12'd5),     1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1,
         mk(11, 12, 5, 1, 1, 2'b11, 0, 0, 0, 0, 0));
    step(0, 1, 0, sw_ins(11, 12, 5'd4),     1, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 1,
         mk(4, 12, 11, 0, 1, 2'b00, 0, 1, 0, 0, 0));
    step(0, 1, 0, jal_ins(1),               1, 0, 0, 0, 0, 2'b00, 2'b10, 1, 0, 1,
         mk(1, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 1));
    // reset with all stages full; illegal + taken branch must stay silent
    step(1, 1, 1, 32'h0000_007F,            1, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1, 0, NOREC);
    step(0, 1, 0, lui_ins(5),               1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1,
         mk(5, 0, 0, 1, 1, 2'b00, 0, 0, 0, 0, 0));
    step(0, 0, 0, 32'h0,                    1, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0, NOREC);
    step(0, 0, 0, 32'h0,                    1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, NOREC);
    step(0, 0, 0, 32'h0,                    1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 0, NOREC);
    // both stages write x3: EX/MEM must win on both operands
    step(0, 1, 0, i_ins(3, 0, 12'd1),       1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1,
         mk(3, 0, 1, 1, 1, 2'b11, 0, 0, 0, 0, 0));
    step(0, 1, 0, i_ins(3, 0, 12'd2),       1, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 1,
         mk(3, 0, 2, 1, 1, 2'b11, 0, 0, 0, 0, 0));
    step(0, 1, 0, r_ins(4, 3, 3),           1, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 1,
         mk(4, 3, 3, 1, 0, 2'b10, 0, 0, 0, 0, 0));
    step(0, 0, 0, 32'h0,                    1, 0, 0, 0, 0, 2'b10, 2'b10, 1, 1, 0, NOREC);
    step(0, 0, 0, 32'h0,                    1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 0, NOREC);
    step(0, 0, 0, 32'h0,                    1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 0, NOREC);
    step(0, 0, 0, 32'h0,                    1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, NOREC);
    @(negedge clk);
    #1;
    chk("queues_drained", 64'(exq.size() + memq.size() + wbq.size() + cycq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
